// File: rtl/mbist_march_ctrl_if.sv
// Single-port test-memory bus between the MBIST controller (master) and the memory under test (slave).
// Bus contract: write_read=1 writes, 0 reads; the memory stores the wdata it sampled one edge earlier,
// and rdata for a read addressed in cycle t is presented during cycle t+2. There is no back-pressure.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, output address, output wdata, input rdata);
  modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller with a 2-deep read-compare pipeline and first-failure diagnostics.
// Optional macro STOP_ON_FAIL_EN: the first mismatch ends the run immediately.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [15:0]           fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [3:0]            state_dbg,
  mbist_march_ctrl_if.master    mem
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_M0,
    S_M1_RD, S_M1_WR, S_M2_RD, S_M2_WR,
    S_M3_RD, S_M3_WR, S_M4_RD, S_M4_WR,
    S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(CAPACITY);
  localparam logic [DATA_WIDTH-1:0] ZEROS = '0;
  localparam logic [DATA_WIDTH-1:0] ONES  = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  drain_cnt;

  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;

  logic start_ok, mismatch, stop_now;

  function automatic logic [2:0] elem_of(input state_t s);
    case (s)
      S_M1_RD, S_M1_WR: return 3'd1;
      S_M2_RD, S_M2_WR: return 3'd2;
      S_M3_RD, S_M3_WR: return 3'd3;
      S_M4_RD, S_M4_WR: return 3'd4;
      S_M5:             return 3'd5;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic logic is_read(input state_t s);
    return (s == S_M1_RD) || (s == S_M2_RD) || (s == S_M3_RD) || (s == S_M4_RD) || (s == S_M5);
  endfunction

  // Background expected by the reads of each element: r1 in M2 and M4, r0 elsewhere.
  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? ONES : ZEROS;
  endfunction

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign mismatch = s2_valid && (mem.rdata != s2_exp);

`ifdef STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign mem.write_read = wr;
  assign mem.address    = addr;
  assign mem.wdata      = wdata_r;
  assign state_dbg      = state;

  // Sequencer: wdata changes only on the edge entering an element, one cycle ahead of its first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      wr        <= 1'b0;
      wdata_r   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
    end else if (stop_now) begin
      state <= S_DONE;
      busy  <= 1'b0;
      done  <= 1'b1;
      wr    <= 1'b0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_SETUP;
            busy    <= 1'b1;
            done    <= 1'b0;
            wdata_r <= ZEROS;
            wr      <= 1'b0;
            addr    <= '0;
          end
        end
        S_SETUP: begin
          state   <= S_M0;
          wr      <= 1'b1;
          addr    <= '0;
          wdata_r <= ZEROS;
        end
        S_M0: begin
          if (addr == LAST) begin
            state   <= S_M1_RD;
            wr      <= 1'b0;
            addr    <= '0;
            wdata_r <= ONES;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_M1_RD: begin state <= S_M1_WR; wr <= 1'b1; end
        S_M2_RD: begin state <= S_M2_WR; wr <= 1'b1; end
        S_M3_RD: begin state <= S_M3_WR; wr <= 1'b1; end
        S_M4_RD: begin state <= S_M4_WR; wr <= 1'b1; end
        S_M1_WR: begin
          wr <= 1'b0;
          if (addr == LAST) begin
            state <= S_M2_RD; addr <= '0; wdata_r <= ZEROS;
          end else begin
            state <= S_M1_RD; addr <= addr + 1'b1;
          end
        end
        S_M2_WR: begin
          wr <= 1'b0;
          if (addr == LAST) begin
            state <= S_M3_RD; addr <= LAST; wdata_r <= ONES;
          end else begin
            state <= S_M2_RD; addr <= addr + 1'b1;
          end
        end
        S_M3_WR: begin
          wr <= 1'b0;
          if (addr == '0) begin
            state <= S_M4_RD; addr <= LAST; wdata_r <= ZEROS;
          end else begin
            state <= S_M3_RD; addr <= addr - 1'b1;
          end
        end
        S_M4_WR: begin
          wr <= 1'b0;
          if (addr == '0) begin
            state <= S_M5; addr <= '0; wdata_r <= ZEROS;
          end else begin
            state <= S_M4_RD; addr <= addr - 1'b1;
          end
        end
        S_M5: begin
          if (addr == LAST) begin
            state     <= S_DRAIN;
            addr      <= '0;
            drain_cnt <= 1'b0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read tags travel two stages so they line up with rdata from the 2-cycle memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_exp     <= '0;
      s2_exp     <= '0;
      s1_addr    <= '0;
      s2_addr    <= '0;
      s1_elem    <= '0;
      s2_elem    <= '0;
      fail       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_data  <= '0;
    end else begin
      s1_valid <= is_read(state) && !stop_now;
      s1_exp   <= rd_bg(elem_of(state));
      s1_addr  <= addr;
      s1_elem  <= elem_of(state);
      s2_valid <= s1_valid && !stop_now;
      s2_exp   <= s1_exp;
      s2_addr  <= s1_addr;
      s2_elem  <= s1_elem;
      if (start_ok) begin
        fail       <= 1'b0;
        fail_count <= '0;
        fail_addr  <= '0;
        fail_elem  <= '0;
        fail_data  <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 1'b1;
        if (!fail) begin
          fail_addr <= s2_addr;
          fail_elem <= s2_elem;
          fail_data <= mem.rdata ^ s2_exp;
        end
      end
    end
  end

endmodule
